// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared widths and encodings for the PRG/CHR ROM port arbiter.
package rom_arbiter_pkg;
  localparam int ROM_AW = 21;
  localparam int EXT_AW = 22;
  localparam int CNT_W = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_WAIT} state_e;
  typedef enum logic {CH_PRG = 1'b0, CH_CHR = 1'b1} chan_e;
endpackage

// File: rtl/rom_arbiter_line.sv
// rom_arbiter_line: one-entry last-address cache line with hit compare, fill and flush.
module rom_arbiter_line
  import rom_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [ROM_AW-1:0] addr_i,
  input  logic              flush_i,
  input  logic              upd_i,
  input  logic [7:0]        wdata_i,
  output logic              hit_o,
  output logic [7:0]        data_o
);
  logic              valid_q;
  logic [ROM_AW-1:0] tag_q;
  logic [7:0]        data_q;
  // a flush in the same cycle as the compare must not produce a hit
  assign hit_o  = valid_q && tag_q == addr_i && !flush_i;
  assign data_o = data_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (upd_i) begin
      valid_q <= 1'b1;
      tag_q   <= addr_i;
      data_q  <= wdata_i;
    end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one external ROM port between PRG and CHR fetch channels,
// with a last-address cache per channel, round-robin/CHR-priority arbitration and a timeout.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter logic [EXT_AW-1:0] CHRBASE = 22'h200000,
  parameter logic              CHRPRIO = 1'b0,
  parameter int                TOUT    = 1023
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ROM_AW-1:0] promaddr,
  input  logic              promreq,
  output logic              promack,
  output logic [7:0]        promdata,
  input  logic [ROM_AW-1:0] cromaddr,
  input  logic              cromreq,
  output logic              cromack,
  output logic [7:0]        cromdata,
  input  logic              flush,
  output logic [EXT_AW-1:0] extaddr,
  output logic              extreq,
  input  logic              extack,
  input  logic [7:0]        extrdata,
  output logic              err
);
  localparam logic [CNT_W-1:0] TLIM = CNT_W'(TOUT - 1);
  state_e            st_q;
  chan_e             gnt_q, rr_q, pick;
  logic [CNT_W-1:0]  cnt_q;
  logic              flushed_q, extreq_q, err_q, pack_q, cack_q;
  logic [EXT_AW-1:0] extaddr_q;
  logic [7:0]        pdata_q, cdata_q, p_line, c_line;
  logic              p_hit, c_hit, p_live, c_live, p_miss, c_miss, done, tmo, upd_p, upd_c;
  rom_arbiter_line u_prg (
    .clk(clk), .resetn(resetn), .addr_i(promaddr), .flush_i(flush), .upd_i(upd_p),
    .wdata_i(extrdata), .hit_o(p_hit), .data_o(p_line)
  );
  rom_arbiter_line u_chr (
    .clk(clk), .resetn(resetn), .addr_i(cromaddr), .flush_i(flush), .upd_i(upd_c),
    .wdata_i(extrdata), .hit_o(c_hit), .data_o(c_line)
  );
  // a channel is deaf in its ack cycle and while its own miss is in flight
  assign p_live = promreq && !pack_q && !(st_q != ST_IDLE && gnt_q == CH_PRG);
  assign c_live = cromreq && !cack_q && !(st_q != ST_IDLE && gnt_q == CH_CHR);
  assign p_miss = p_live && !p_hit;
  assign c_miss = c_live && !c_hit;
  assign pick   = (c_miss && (CHRPRIO || !p_miss || rr_q == CH_PRG)) ? CH_CHR : CH_PRG;
  assign done   = st_q == ST_WAIT && extack;
  assign tmo    = st_q == ST_WAIT && !extack && cnt_q == TLIM;
  assign upd_p  = done && gnt_q == CH_PRG && !flush && !flushed_q;
  assign upd_c  = done && gnt_q == CH_CHR && !flush && !flushed_q;
  assign promack  = pack_q;
  assign promdata = pdata_q;
  assign cromack  = cack_q;
  assign cromdata = cdata_q;
  assign extaddr  = extaddr_q;
  assign extreq   = extreq_q;
  assign err      = err_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st_q      <= ST_IDLE;
      gnt_q     <= CH_PRG;
      rr_q      <= CH_PRG;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      extaddr_q <= '0;
      extreq_q  <= 1'b0;
      err_q     <= 1'b0;
      pack_q    <= 1'b0;
      cack_q    <= 1'b0;
      pdata_q   <= '0;
      cdata_q   <= '0;
    end else begin
      pack_q <= p_live && p_hit;
      cack_q <= c_live && c_hit;
      if (p_live && p_hit) pdata_q <= p_line;
      if (c_live && c_hit) cdata_q <= c_line;
      case (st_q)
        ST_IDLE:
          if (p_miss || c_miss) begin
            st_q      <= ST_GRANT;
            gnt_q     <= pick;
            rr_q      <= pick;
            flushed_q <= 1'b0;
            extaddr_q <= pick == CH_CHR ? CHRBASE + EXT_AW'(cromaddr) : EXT_AW'(promaddr);
          end
        ST_GRANT: begin
          st_q      <= ST_WAIT;
          extreq_q  <= 1'b1;
          cnt_q     <= '0;
          flushed_q <= flushed_q | flush;
        end
        default: begin
          cnt_q     <= cnt_q + CNT_W'(1);
          flushed_q <= flushed_q | flush;
          if (done || tmo) begin
            st_q     <= ST_IDLE;
            extreq_q <= 1'b0;
            err_q    <= err_q | tmo;
            if (gnt_q == CH_CHR) begin
              cack_q  <= 1'b1;
              cdata_q <= done ? extrdata : 8'hFF;
            end else begin
              pack_q  <= 1'b1;
              pdata_q <= done ? extrdata : 8'hFF;
            end
          end
        end
      endcase
    end
endmodule
